bcd_cascade_ctrl: RTL and testbench

//  Sequencer for a cascade of DIGITS bcd counter digits (digit 0 = least significant) forming a multi-digit timer.
//  - Generates a prescaled count tick and one-cycle preset loads.
//  - Gates per-digit enables from the digits' carry outputs and latches count direction.
//  - Detects terminal count and flags completion.

---
 rtl/bcd_cascade_ctrl.sv | 121 ++++++++++++
 tb/tb_bcd_cascade_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_cascade_ctrl.sv
// Sequencer for a cascade of BCD counter digits: prescaled count tick, carry-gated
// per-digit enables, preset load strobe, direction latch and terminal-count detection.
module bcd_cascade_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10,
  parameter int WRAP     = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              stop,
  input  logic              load_req,
  input  logic              dir_up,
  input  logic [DIGITS-1:0] digit_co,
  output logic [DIGITS-1:0] digit_en,
  output logic              digit_load,
  output logic              digit_up,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam bit WRAP_EN = (WRAP != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            done_q, done_d;
  logic            tick, term, wrap;
  logic            carry;

  // A stop arriving on the tick cycle suppresses the tick entirely.
  assign tick = (state_q == S_RUN) && (cnt_q == CNT_MAX) && !stop;
  assign term = tick && (&digit_co);
  assign wrap = term && dir_q && WRAP_EN;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          state_d = S_LOAD;
        end else if (start) begin
          state_d = S_RUN;
          dir_d   = dir_up;
        end
      end
      S_LOAD: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      S_RUN: begin
        // The prescaler freezes on the stop cycle so a resume continues where it left off.
        if (!stop) cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        if (stop) begin
          state_d = S_PAUSE;
        end else if (term && !wrap) begin
          state_d = S_DONE;
        end
      end
      S_PAUSE: begin
        if (load_req) begin
          state_d = S_LOAD;
        end else if (start && !stop) begin
          state_d = S_RUN;
          dir_d   = dir_up;
        end
      end
      S_DONE: begin
        if (load_req) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_comb begin
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      digit_en[i] = tick && carry;
      carry       = carry && digit_co[i];
    end
    if (state_q == S_LOAD) begin
      digit_en = '1;
    end else if (term && !wrap) begin
      digit_en = '0;
    end
    digit_load = (state_q == S_LOAD);
    busy       = (state_q == S_RUN);
    digit_up   = dir_q;
    done       = done_q;
    state      = state_q;
  end

endmodule

// File: tb/tb_bcd_cascade_ctrl.sv
// Directed table-driven bench for bcd_cascade_ctrl: two 2-digit instances differing only
// in WRAP share stimulus; a 1-digit PRESCALE=1 instance covers the every-cycle tick case.
module tb_bcd_cascade_ctrl;

  logic       clk = 1'b0;
  logic       clr, start, stop, load_req, dir_up;
  logic [1:0] co;
  logic       co_c;

  logic [1:0] en_a, en_b;
  logic       ld_a, up_a, bz_a, dn_a;
  logic       ld_b, up_b, bz_b, dn_b;
  logic [2:0] st_a, st_b;
  logic [0:0] en_c;
  logic       ld_c, up_c, bz_c, dn_c;
  logic [2:0] st_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_cascade_ctrl #(.DIGITS(2), .PRESCALE(4), .WRAP(0)) u_a (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .load_req(load_req), .dir_up(dir_up),
    .digit_co(co), .digit_en(en_a), .digit_load(ld_a), .digit_up(up_a), .busy(bz_a),
    .done(dn_a), .state(st_a));

  bcd_cascade_ctrl #(.DIGITS(2), .PRESCALE(4), .WRAP(1)) u_b (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .load_req(load_req), .dir_up(dir_up),
    .digit_co(co), .digit_en(en_b), .digit_load(ld_b), .digit_up(up_b), .busy(bz_b),
    .done(dn_b), .state(st_b));

  bcd_cascade_ctrl #(.DIGITS(1), .PRESCALE(1), .WRAP(0)) u_c (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .load_req(load_req), .dir_up(dir_up),
    .digit_co(co_c), .digit_en(en_c), .digit_load(ld_c), .digit_up(up_c), .busy(bz_c),
    .done(dn_c), .state(st_c));

  typedef struct {
    bit       lr, st, sp, dir;
    bit [1:0] co;
    bit [2:0] est;
    bit [1:0] een;
    bit       eld, ebz, edn, eup;
    bit [2:0] est_b;
    bit [1:0] een_b;
    bit       edn_b;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit lr, bit st, bit sp, bit dir, bit [1:0] c,
                              bit [2:0] est, bit [1:0] een, bit eld, bit ebz, bit edn, bit eup);
    vec_t v;
    v.lr = lr; v.st = st; v.sp = sp; v.dir = dir; v.co = c;
    v.est = est; v.een = een; v.eld = eld; v.ebz = ebz; v.edn = edn; v.eup = eup;
    v.est_b = est; v.een_b = een; v.edn_b = edn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; stop = 1'b0; load_req = 1'b0; dir_up = 1'b0;
    co = 2'b00; co_c = 1'b0;

    // lr st sp dir co | state en load busy done up
    tbl.push_back(mk(1,1,0,1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0, 1,3,1,0,0,0));
    tbl.push_back(mk(0,1,0,1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,1,0, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,1,0, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,1,0, 2,1,0,1,0,1));
    tbl.push_back(mk(0,0,0,1,1, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,1,1, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,1, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,1, 2,3,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,2, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,2, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,2, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,2, 2,1,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,3, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,3, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,3, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,3, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,0,0, 4,0,0,0,1,1));
    tbl.push_back(mk(0,1,1,0,0, 4,0,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0, 4,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0, 1,3,1,0,0,1));
    tbl.push_back(mk(0,1,0,0,3, 0,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,3, 2,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,3, 2,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,3, 2,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,3, 2,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,3, 4,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,3, 4,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 4,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,3,1,0,0,0));
    tbl.push_back(mk(0,1,0,1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,1,0, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,1,1,0, 2,0,0,1,0,1));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0,0,1,1,0, 3,0,0,0,0,1));
    tbl.push_back(mk(0,1,0,1,0, 3,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,1,0, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,1,0, 2,1,0,1,0,1));
    tbl.push_back(mk(0,0,0,1,0, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,1,0, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,1,0, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,1,1,0, 2,0,0,1,0,1));
    tbl.push_back(mk(0,1,1,1,0, 3,0,0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0, 3,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0, 2,1,0,1,0,0));
    tbl.push_back(mk(0,0,1,0,0, 2,0,0,1,0,0));
    tbl.push_back(mk(1,1,0,0,0, 3,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,3,1,0,0,0));
    tbl.push_back(mk(0,1,1,1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,1,0, 2,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,1,0, 3,0,0,0,0,1));

    // Wrapping instance diverges at the all-9s up tick until both take the load.
    tbl[18].een_b = 2'b11;
    tbl[19].est_b = 3'd2; tbl[19].edn_b = 1'b0;
    tbl[20].est_b = 3'd2;
    tbl[21].est_b = 3'd3;

    repeat (2) @(negedge clk);
    #1;
    chk("rst state_a", st_a, 0);
    chk("rst en_a", en_a, 0);
    chk("rst load_a", ld_a, 0);
    chk("rst busy_a", bz_a, 0);
    chk("rst done_a", dn_a, 0);
    chk("rst up_a", up_a, 0);
    @(negedge clk);
    clr = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      load_req = tbl[i].lr; start = tbl[i].st; stop = tbl[i].sp;
      dir_up = tbl[i].dir; co = tbl[i].co;
      #1;
      chk($sformatf("r%0d state_a", i), st_a, tbl[i].est);
      chk($sformatf("r%0d en_a", i), en_a, tbl[i].een);
      chk($sformatf("r%0d load_a", i), ld_a, tbl[i].eld);
      chk($sformatf("r%0d busy_a", i), bz_a, tbl[i].ebz);
      chk($sformatf("r%0d done_a", i), dn_a, tbl[i].edn);
      chk($sformatf("r%0d up_a", i), up_a, tbl[i].eup);
      chk($sformatf("r%0d state_b", i), st_b, tbl[i].est_b);
      chk($sformatf("r%0d en_b", i), en_b, tbl[i].een_b);
      chk($sformatf("r%0d done_b", i), dn_b, tbl[i].edn_b);
      chk($sformatf("r%0d busy_b", i), bz_b, tbl[i].est_b == 3'd2);
      chk($sformatf("r%0d up_b", i), up_b, tbl[i].eup);
    end

    // Async clear in the middle of a tick cycle.
    @(negedge clk);
    load_req = 1'b0; start = 1'b1; stop = 1'b0; dir_up = 1'b1; co = 2'b00;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre-clr en_a", en_a, 1);
    chk("pre-clr state_a", st_a, 2);
    #2;
    clr = 1'b0;
    #1;
    chk("clr state_a", st_a, 0);
    chk("clr en_a", en_a, 0);
    chk("clr busy_a", bz_a, 0);
    chk("clr up_a", up_a, 0);
    chk("clr state_b", st_b, 0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    #1;
    chk("post-clr state_a", st_a, 0);
    chk("post-clr load_a", ld_a, 0);

    // PRESCALE=1, single digit: tick on every RUN cycle, terminal without wrap stops.
    @(negedge clk);
    start = 1'b1; dir_up = 1'b1; co_c = 1'b0;
    #1;
    chk("c idle", st_c, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("c run", st_c, 2);
    chk("c en0", en_c, 1);
    @(negedge clk);
    #1;
    chk("c en1", en_c, 1);
    @(negedge clk);
    co_c = 1'b1;
    #1;
    chk("c term en", en_c, 0);
    @(negedge clk);
    #1;
    chk("c done state", st_c, 4);
    chk("c done", dn_c, 1);
    @(negedge clk);
    #1;
    chk("c done pulse", dn_c, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
